// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg
// Shared definitions for the LEGv8 instruction packer: operation classes,
// fixed opcode bit patterns, immediate field widths and the FSM states.
// No ports (package).
package imm_enc_pkg;

    typedef enum logic [2:0] {
        OP_LDUR  = 3'd0,
        OP_STUR  = 3'd1,
        OP_ADDI  = 3'd2,
        OP_CBZ   = 3'd3,
        OP_CBNZ  = 3'd4,
        OP_BCOND = 3'd5,
        OP_B     = 3'd6,
        OP_ILL   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_e;

    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [5:0]  OPC_B     = 6'b000101;

    localparam logic [5:0] W_LDST = 6'd9;
    localparam logic [5:0] W_ADDI = 6'd12;
    localparam logic [5:0] W_CB   = 6'd19;
    localparam logic [5:0] W_B    = 6'd26;

    // Immediate field width of an op class; 0 marks the illegal class so the
    // fit check can never pass for it.
    function automatic logic [5:0] field_w(input op_e op);
        case (op)
            OP_LDUR, OP_STUR:          field_w = W_LDST;
            OP_ADDI:                   field_w = W_ADDI;
            OP_CBZ, OP_CBNZ, OP_BCOND: field_w = W_CB;
            OP_B:                      field_w = W_B;
            default:                   field_w = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/imm_fit_check.sv
// imm_fit_check
// Combinational check that a 64-bit signed immediate narrows losslessly into
// a w-bit two's-complement field (imm[63:w-1] all equal).
// Ports:
//   imm  in  64  signed immediate
//   w    in  6   field width (0 means "never fits")
//   fits out 1   immediate is representable in w bits
module imm_fit_check (
    input  logic [63:0] imm,
    input  logic [5:0]  w,
    output logic        fits
);

    logic signed [63:0] imm_s;
    logic signed [63:0] sh;

    assign imm_s = $signed(imm);

    // After dropping the low w-1 bits arithmetically, only the sign copies
    // remain; the value fits when those are all zeros or all ones.
    always_comb begin
        sh   = '0;
        fits = 1'b0;
        if (w != 6'd0) begin
            sh   = imm_s >>> (w - 6'd1);
            fits = (sh == '0) || (sh == '1);
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder
// Packs (op class, Rt, Rn, signed immediate) requests into 32-bit LEGv8
// words and streams them with sequential byte addresses toward the
// instruction-memory loader. A range or op-class violation parks the block
// in an error state until clr_err.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, base_addr, len    burst launch (honoured only when idle)
//   in_valid/in_ready        request handshake; in_op/in_rt/in_rn/in_imm fields
//   out_valid/out_ready      packed-word handshake; out_word, out_addr
//   done                     one-cycle pulse at burst completion
//   err, err_op, clr_err     sticky error, offending op class, error clear
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rn,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_op,
    input  logic              clr_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       remain_q, remain_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        err_op_q, err_op_d;

    op_e               op;
    logic [5:0]        fw;
    logic              fits;
    logic              legal;
    logic              in_ready_c;
    logic              in_fire;
    logic              out_fire;

    function automatic logic [31:0] pack_word(
        input op_e         op_i,
        input logic [4:0]  rt,
        input logic [4:0]  rn,
        input logic [63:0] imm
    );
        case (op_i)
            OP_LDUR:  pack_word = {OPC_LDUR, imm[8:0], 2'b00, rn, rt};
            OP_STUR:  pack_word = {OPC_STUR, imm[8:0], 2'b00, rn, rt};
            OP_ADDI:  pack_word = {OPC_ADDI, imm[11:0], rn, rt};
            OP_CBZ:   pack_word = {OPC_CBZ, imm[18:0], rt};
            OP_CBNZ:  pack_word = {OPC_CBNZ, imm[18:0], rt};
            OP_BCOND: pack_word = {OPC_BCOND, imm[18:0], 1'b0, rt[3:0]};
            OP_B:     pack_word = {OPC_B, imm[25:0]};
            default:  pack_word = '0;
        endcase
    endfunction

    assign op = op_e'(in_op);
    assign fw = field_w(op);

    imm_fit_check u_fit (
        .imm  (in_imm),
        .w    (fw),
        .fits (fits)
    );

    assign legal    = (op != OP_ILL) && fits;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        in_ready_c = 1'b0;
        if (state_q == ST_ACTIVE) begin
            // Once the last word is taken, stop accepting until the burst ends.
            in_ready_c = (remain_q != 16'd0) && (!out_valid_q || out_ready);
        end
    end

    assign in_fire = in_valid && in_ready_c;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        last_d      = last_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_op_d    = err_op_q;

        // A held word drains in every state, including after an error.
        if (out_fire) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = len;
                    if (len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (out_fire && last_q) begin
                    state_d = ST_IDLE;
                end
                if (in_fire) begin
                    if (legal) begin
                        out_valid_d = 1'b1;
                        out_word_d  = pack_word(op, in_rt, in_rn, in_imm);
                        out_addr_d  = addr_q;
                        addr_d      = addr_q + ADDR_W'(4);
                        remain_d    = remain_q - 16'd1;
                        last_d      = (remain_q == 16'd1);
                    end else begin
                        err_d    = 1'b1;
                        err_op_d = in_op;
                        state_d  = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    err_d    = 1'b0;
                    remain_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            last_q      <= last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_op_q    <= err_op_d;
        end
    end

    // The completion pulse for a non-empty burst coincides with the final
    // output handshake; an empty burst pulses one cycle after start.
    assign done      = done_q || (out_fire && last_q);
    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_op    = err_op_q;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction-word packer that does the opposite of the sign extender in the decode path. It takes an operation class, register fields and a 64-bit signed immediate, checks that the immediate narrows losslessly into the format's field, and packs a 32-bit LEGv8 word. Packed words are streamed with sequential word addresses into the instruction-memory loader. It sits between the test/boot program source and instruction memory.

## Interface
- ADDR_W, 16: width of the word-address output (byte address, increments by 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; load base/len and begin a burst (honoured only in IDLE)
- base_addr  in  ADDR_W  byte address of the first word
- len  in  16  number of words in the burst
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  3  op class: 0 LDUR, 1 STUR, 2 ADDI, 3 CBZ, 4 CBNZ, 5 B.cond, 6 B (7 is illegal)
- in_rt  in  5  Rt/Rd field; for B.cond, in_rt[3:0] is the condition
- in_rn  in  5  Rn field
- in_imm  in  64  signed immediate (word offset for CB/B)
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_word  out  32  packed instruction
- out_addr  out  ADDR_W  byte address of out_word
- done  out  1  one-cycle pulse when the burst completes
- err  out  1  sticky range/illegal-op error
- err_op  out  3  in_op of the offending request
- clr_err  in  1  clears err and returns the FSM to IDLE

## Operation
- States are IDLE, ACTIVE and ERR. Reset enters IDLE.
- IDLE: in_ready=0. On start, load addr←base_addr and remain←len, then go to ACTIVE. If len=0, done pulses the next cycle and the state stays IDLE.
- ACTIVE: in_ready = !out_valid || out_ready (single output register with backpressure).
- Fit rule: the immediate is legal iff in_imm[63:W-1] are all equal.
  - W=9 for LDUR/STUR, range −256..255.
  - W=12 for ADDI, range −2048..2047.
  - W=19 for CBZ/CBNZ/B.cond.
  - W=26 for B.
- Packing. Each format below gives the fixed opcode and its field positions.
  - LDUR: opcode [31:21]=11111000010, imm9 [20:12], [11:10]=00, Rn [9:5], Rt [4:0].
  - STUR: opcode [31:21]=11111000000, with the same field layout as LDUR.
  - ADDI: opcode [31:22]=1001000100, imm12 [21:10], Rn [9:5], Rd [4:0].
  - CBZ: opcode [31:24]=10110100, imm19 [23:5], Rt [4:0].
  - CBNZ: opcode [31:24]=10110101, with the same field layout as CBZ.
  - B.cond: opcode [31:24]=01010100, imm19 [23:5], [4]=0, cond [3:0].
  - B: opcode [31:26]=000101, imm26 [25:0].
- Accepted legal request: out_word and out_addr←addr are registered and out_valid is set. addr += 4, wrapping mod 2^ADDR_W. remain −= 1.
- Completion: when the output handshake completes for the word that brought remain to 0, done pulses in that cycle and the FSM goes to IDLE.
- Accepted request with an illegal immediate or in_op=7:
  - No word is emitted, and addr and remain are unchanged.
  - err=1, err_op is captured, and the FSM goes to ERR.
  - A word already held in the output register still drains normally.
- ERR: in_ready=0. clr_err clears err and enters IDLE, discarding the remaining count.
- start outside IDLE is ignored.
- Reset mid-burst: all state clears immediately and any pending word is lost.

## Timing
- Reset values: in_ready=0, out_valid=0, out_word=0, out_addr=0, done=0, err=0, err_op=0.
- Latency: a request accepted in cycle N appears on out_* in cycle N+1.
- Throughput: one word per cycle while out_ready=1.
- Backpressure: out_* hold stable while out_valid && !out_ready.
- A simultaneous output handshake and new input acceptance in the same cycle is legal and replaces the word.
- Error: err is high in cycle N+1 after the offending acceptance.
- clr_err takes effect on the next edge.
- If clr_err and start arrive in the same cycle while in ERR, start is ignored.

## Structure
- Package imm_enc_pkg holds the op-class enum, the opcode constants, the field widths W per class, and the FSM state enum.
- One sub-module, imm_fit_check: a combinational pure function of (imm, W) that returns fits.

## Test plan
- Basic burst: start base=0x100, len=3, then requests ADDI rd=1 rn=2 imm=5, LDUR rt=3 rn=4 imm=−8, B imm=−1.
  - Expected words: 0x91001441 @0x100, 0xF85F8083 @0x104, 0x17FFFFFF @0x108.
  - done pulses with the third handshake.
- Boundaries: ADDI imm=2047 is accepted as 0x911FFC00 (rd=rn=0); ADDI imm=2048 gives err=1, err_op=2, and no word.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - out_word is stable and in_ready=0.
  - On release, words stream back-to-back with no loss or duplication.
- Address wrap: ADDR_W=16, base=0xFFFC, len=2 gives addresses 0xFFFC then 0x0000.
- Error recovery: send op=7, then clr_err, then start len=1 CBZ rt=0 imm=0x3FFFF.
  - Expect 0xB47FFFE0 and done.
- Reset mid-burst: assert rst_n=0 with out_valid=1. All outputs go to 0 asynchronously and the FSM returns to IDLE.
